// File: rtl/tx_rd_chunk_scheduler_pkg.sv
// Shared types, widths and helpers for the huge-page read chunk scheduler.
package tx_rd_chunk_scheduler_pkg;

    localparam int unsigned LEN_W               = 19;
    localparam int unsigned OUT_W               = 5;
    localparam int unsigned QW_PER_4K           = 512;
    localparam int unsigned DEF_CHUNK_QW        = 64;
    localparam int unsigned DEF_MAX_OUTSTANDING = 8;
    localparam int unsigned DESC_W              = 64 + LEN_W;

    typedef enum logic [6:0] {
        StIdle   = 7'b000_0001,
        StLoad   = 7'b000_0010,
        StReq    = 7'b000_0100,
        StDrain  = 7'b000_1000,
        StNotify = 7'b001_0000,
        StIrq    = 7'b010_0000,
        StPop    = 7'b100_0000
    } state_e;

    typedef struct packed {
        logic [63:0]      addr;
        logic [LEN_W-1:0] len;
    } hp_desc_t;

    // Largest legal chunk: capped by the chunk limit, the bytes left in the page and
    // the distance to the next 4 KB boundary (qw_off is the qword offset within 4 KB).
    function automatic logic [8:0] chunk_len(input logic [8:0]       qw_off,
                                             input logic [LEN_W-1:0] rem,
                                             input int unsigned      max_qw);
        logic [LEN_W-1:0] best;
        logic [LEN_W-1:0] to_4k;
        best  = LEN_W'(max_qw);
        to_4k = LEN_W'(QW_PER_4K) - LEN_W'(qw_off);
        if (to_4k < best) best = to_4k;
        if (rem < best) best = rem;
        return 9'(best);
    endfunction

endpackage

// File: rtl/tx_rd_chunk_scheduler_hp_desc_fifo.sv
// Small descriptor FIFO holding {addr, len} pairs for queued huge pages.
module hp_desc_fifo
    import tx_rd_chunk_scheduler_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                   trn_clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  hp_desc_t               push_data_i,
    input  logic                   pop_i,
    output hp_desc_t               head_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    hp_desc_t [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    // FIFO state registers.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tx_rd_chunk_scheduler.sv
// Walks queued huge pages in 4 KB-safe read chunks, throttles in-flight reads and
// raises the per-page completion notification and optional interrupt.
module tx_rd_chunk_scheduler
    import tx_rd_chunk_scheduler_pkg::*;
#(
    parameter int unsigned NUMB_HP         = 2,
    parameter int unsigned CHUNK_QW        = DEF_CHUNK_QW,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic             trn_clk,
    input  logic             reset_n,
    input  logic             hp_load,
    input  logic [63:0]      hp_load_addr,
    input  logic [LEN_W-1:0] hp_load_len_qw,
    output logic             hp_ready,
    input  logic             irq_en,
    output logic [63:0]      huge_page_addr,
    output logic [8:0]       qwords_to_rd,
    output logic             read_chunk,
    input  logic             read_chunk_ack,
    output logic             send_huge_page_rd_completed,
    input  logic             send_huge_page_rd_completed_ack,
    output logic             send_interrupt,
    input  logic             send_interrupt_ack,
    input  logic             cpl_chunk_done,
    output logic [OUT_W-1:0] outstanding,
    output logic             hp_overflow,
    output logic             cpl_underflow
);

    localparam int unsigned CNT_W = $clog2(NUMB_HP) + 1;

    state_e           state_q, state_d;
    logic [63:0]      cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0] rem_qw_q, rem_qw_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [8:0]       qwords_q, qwords_d;
    logic             read_chunk_q, read_chunk_d;
    logic             notify_q, notify_d;
    logic             irq_q, irq_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    hp_desc_t         fifo_in, fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             chunk_ack;

    assign fifo_push    = hp_load && !fifo_full;
    assign fifo_in.addr = hp_load_addr & ~64'h7;
    assign fifo_in.len  = hp_load_len_qw;
    assign chunk_ack    = read_chunk_q && read_chunk_ack;

    hp_desc_fifo #(
        .Depth (NUMB_HP)
    ) u_desc_fifo (
        .trn_clk     (trn_clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Page walk: latch the head descriptor, then advance by each accepted chunk.
    always_comb begin
        cur_addr_d = cur_addr_q;
        rem_qw_d   = rem_qw_q;
        if (state_q == StLoad) begin
            cur_addr_d = fifo_head.addr;
            rem_qw_d   = fifo_head.len;
        end else if (chunk_ack) begin
            cur_addr_d = cur_addr_q + {52'd0, qwords_q, 3'b000};
            rem_qw_d   = rem_qw_q - LEN_W'(qwords_q);
        end
    end

    // In-flight counter; a completion with nothing outstanding is flagged, not counted.
    always_comb begin
        out_d       = out_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q | (hp_load && fifo_full);
        if (chunk_ack && !cpl_chunk_done) begin
            out_d = out_q + OUT_W'(1);
        end else if (!chunk_ack && cpl_chunk_done) begin
            if (out_q == '0) underflow_d = 1'b1;
            else             out_d       = out_q - OUT_W'(1);
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!fifo_empty) state_d = StLoad;
            StLoad:   state_d = (fifo_head.len == '0) ? StDrain : StReq;
            StReq:    if (chunk_ack && rem_qw_d == '0) state_d = StDrain;
            StDrain:  if (out_q == '0) state_d = StNotify;
            StNotify: if (notify_q && send_huge_page_rd_completed_ack) begin
                          state_d = irq_en ? StIrq : StPop;
                      end
            StIrq:    if (irq_q && send_interrupt_ack) state_d = StPop;
            StPop:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs, computed from the next state so requests come straight off flops.
    always_comb begin
        read_chunk_d = (state_d == StReq) && (out_d < OUT_W'(MAX_OUTSTANDING)) && !chunk_ack;
        qwords_d     = (state_d == StReq) ? chunk_len(cur_addr_d[11:3], rem_qw_d, CHUNK_QW)
                                          : 9'd0;
        notify_d     = (state_d == StNotify);
        irq_d        = (state_d == StIrq);
        fifo_pop     = (state_q == StPop);
    end

    // Datapath and registered request outputs.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr_q   <= '0;
            rem_qw_q     <= '0;
            out_q        <= '0;
            qwords_q     <= '0;
            read_chunk_q <= 1'b0;
            notify_q     <= 1'b0;
            irq_q        <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            rem_qw_q     <= rem_qw_d;
            out_q        <= out_d;
            qwords_q     <= qwords_d;
            read_chunk_q <= read_chunk_d;
            notify_q     <= notify_d;
            irq_q        <= irq_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign hp_ready                    = (fifo_count < CNT_W'(NUMB_HP));
    assign huge_page_addr              = cur_addr_q;
    assign qwords_to_rd                = qwords_q;
    assign read_chunk                  = read_chunk_q;
    assign send_huge_page_rd_completed = notify_q;
    assign send_interrupt              = irq_q;
    assign outstanding                 = out_q;
    assign hp_overflow                 = overflow_q;
    assign cpl_underflow               = underflow_q;

endmodule
